itcm_port_arbiter: RTL and testbench
====================================

Name: itcm_port_arbiter

Overview:
- Sequences and shares one single-port ITCM SRAM (one access per cycle) between three requesters: the auto-load writer, instruction fetch (IF) and the AHB debug port.
- Sits between the fetch unit, AHB slave decoder and auto-load engine on one side, and the ITCM macro on the other.
- Provides grants, word-address translation, byte-strobe steering and 1-cycle read-return routing.
- Bounds AHB starvation behind continuous fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width of all requester ports
- DATA_WIDTH, 32, data width
- WORD_AW, 13, SRAM word-address width (8K words, 32 KB)
- ITCM_START_ADDR, 32'h0000_0000, base byte address subtracted before word indexing
- STARVE_LIMIT, 4, consecutive denied AHB cycles after which AHB takes priority over IF

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- load_active  in  1  auto-load sequence in progress
- load_req  in  1  auto-load write valid this cycle
- load_addr  in  ADDR_WIDTH  auto-load byte address
- load_wdata  in  DATA_WIDTH  auto-load write data
- if_req  in  1  instruction read request
- if_addr  in  ADDR_WIDTH  instruction byte address
- if_gnt  out  1  IF request accepted this cycle
- if_rdata  out  DATA_WIDTH  instruction read data
- if_rvalid  out  1  if_rdata valid
- ahb_req  in  1  AHB access request
- ahb_wr  in  1  1 = write, 0 = read
- ahb_addr  in  ADDR_WIDTH  AHB byte address
- ahb_be  in  4  AHB write byte strobes
- ahb_wdata  in  DATA_WIDTH  AHB write data
- ahb_gnt  out  1  AHB request accepted this cycle
- ahb_rdata  out  DATA_WIDTH  AHB read data
- ahb_rvalid  out  1  ahb_rdata valid
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_be  out  4  SRAM byte enables
- sram_addr  out  WORD_AW  SRAM word address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read select

Behaviour:
- FSM states: S_LOAD and S_RUN. Reset enters S_LOAD.
  - S_LOAD -> S_RUN on the first cycle load_active is sampled low.
  - S_RUN -> S_LOAD if load_active rises (reload).
- S_LOAD:
  - Only auto-load is served: sram_cs = sram_we = load_req, sram_be = 4'hF.
  - if_gnt = ahb_gnt = 0. The starve counter holds at 0.
- S_RUN arbitration is combinational, same cycle; at most one grant per cycle:
  - AHB wins if ahb_req && (!if_req || starve_cnt == STARVE_LIMIT).
  - Otherwise IF wins if if_req.
- Starve counter (3 bits):
  - Increments when ahb_req && !ahb_gnt in S_RUN, saturating at STARVE_LIMIT.
  - Clears on ahb_gnt, on !ahb_req, and on entering S_LOAD.
- SRAM drive on a grant:
  - sram_cs = 1.
  - sram_we = winner is AHB && ahb_wr.
  - sram_be = ahb_be for AHB writes, 4'hF otherwise.
  - sram_wdata = winner's data.
  - sram_addr = (addr - ITCM_START_ADDR)[WORD_AW+1:2]. Bits [1:0] are ignored; no range check (the upstream decoder guarantees the hit).
  - With no grant, sram_cs = 0 and the other SRAM outputs are don't-care.
- Read return, fixed latency 1:
  - A registered owner tag (NONE/IF/AHB) is set by the read grant.
  - In the following cycle, the tagged requester's rvalid = 1, and its rdata = sram_rdata (combinational pass-through).
  - Writes produce no rvalid.
  - if_rdata and ahb_rdata both mirror sram_rdata and are qualified only by rvalid.
- Back-to-back reads from alternating requesters are allowed every cycle. An AHB write followed by an IF read of the same word returns the new data (SRAM write-first ordering).
- load_active rising while a read is outstanding: that read's rvalid still asserts next cycle; new grants stop immediately.
- rst asserted mid-operation: all outputs clear asynchronously (grants 0, rvalids 0, sram_cs 0, tag NONE, FSM S_LOAD). Any outstanding read is dropped with no rvalid.
- Reset values: if_gnt 0, ahb_gnt 0, if_rvalid 0, ahb_rvalid 0, sram_cs 0, sram_we 0, sram_be 0, sram_addr 0, sram_wdata 0, if_rdata/ahb_rdata 0.

Test Plan:
- Reset with load_active=1, load_req pulses at 0x0, 0x4, 0x8 -> sram_cs/we=1, be=F, sram_addr 0, 1, 2. if_req held high the whole time -> if_gnt stays 0.
- load_active falls, then if_req at 0x100 -> next cycle if_gnt=1, sram_addr=0x40. The cycle after: if_rvalid=1, if_rdata = SRAM word 0x40.
- if_req held continuous, ahb_req read at 0x200 from cycle N -> ahb_gnt=0 for 4 cycles, then ahb_gnt=1 at N+4 and if_gnt=0 that cycle. ahb_rvalid at N+5 only; IF resumes at N+5.
- AHB write 0x10 with be=4'b0011 and data 0xAABBCCDD, then IF read 0x10 next cycle -> sram_be=3 on the write. if_rdata shows the low 16 bits as CCDD, upper bytes unchanged.
- IF read granted, then load_active rises the next cycle -> if_rvalid still 1 that cycle, no further if_gnt.
- rst pulsed one cycle after an AHB read grant -> ahb_rvalid never asserts, all outputs 0, FSM back in S_LOAD.

Source files
------------

// File: rtl/itcm_port_arbiter_if.sv
// Requester and SRAM-side signal bundle for the ITCM port arbiter.
// slave is the arbiter view; master is the surrounding system view.
interface itcm_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int WORD_AW    = 13
);
   logic                  load_active;
   logic                  load_req;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [DATA_WIDTH-1:0] load_wdata;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_rvalid;

   logic                  ahb_req;
   logic                  ahb_wr;
   logic [ADDR_WIDTH-1:0] ahb_addr;
   logic [3:0]            ahb_be;
   logic [DATA_WIDTH-1:0] ahb_wdata;
   logic                  ahb_gnt;
   logic [DATA_WIDTH-1:0] ahb_rdata;
   logic                  ahb_rvalid;

   logic                  sram_cs;
   logic                  sram_we;
   logic [3:0]            sram_be;
   logic [WORD_AW-1:0]    sram_addr;
   logic [DATA_WIDTH-1:0] sram_wdata;
   logic [DATA_WIDTH-1:0] sram_rdata;

   modport slave (
      input  load_active, load_req, load_addr, load_wdata,
      input  if_req, if_addr,
      output if_gnt, if_rdata, if_rvalid,
      input  ahb_req, ahb_wr, ahb_addr, ahb_be, ahb_wdata,
      output ahb_gnt, ahb_rdata, ahb_rvalid,
      output sram_cs, sram_we, sram_be, sram_addr, sram_wdata,
      input  sram_rdata
   );

   modport master (
      output load_active, load_req, load_addr, load_wdata,
      output if_req, if_addr,
      input  if_gnt, if_rdata, if_rvalid,
      output ahb_req, ahb_wr, ahb_addr, ahb_be, ahb_wdata,
      input  ahb_gnt, ahb_rdata, ahb_rvalid,
      input  sram_cs, sram_we, sram_be, sram_addr, sram_wdata,
      output sram_rdata
   );
endinterface

// File: rtl/itcm_port_arbiter.sv
// Single-port ITCM sharing between auto-load, instruction fetch and AHB
// debug, with bounded AHB starvation and 1-cycle read-return routing.
module itcm_port_arbiter #(
   parameter int              ADDR_WIDTH      = 32,
   parameter int              DATA_WIDTH      = 32,
   parameter int              WORD_AW         = 13,
   parameter logic [31:0]     ITCM_START_ADDR = 32'h0000_0000,
   parameter int              STARVE_LIMIT    = 4
) (
   input logic clk,
   input logic rst,
   itcm_port_arbiter_if.slave bus
);

   typedef enum logic {S_LOAD, S_RUN} state_t;
   typedef enum logic [1:0] {T_NONE, T_IF, T_AHB} tag_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ITCM_START_ADDR);

   state_t r_state, w_state_nxt;
   tag_t   r_tag, w_tag_nxt;
   logic [2:0] r_starve, w_starve_nxt;

   logic                  w_live;
   logic                  w_if_win;
   logic                  w_ahb_win;
   logic                  w_cs;
   logic                  w_we;
   logic [3:0]            w_be;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [ADDR_WIDTH-1:0] w_off;
   logic                  w_unused_off;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_LOAD;
         r_tag    <= T_NONE;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_tag    <= w_tag_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      w_tag_nxt    = T_NONE;
      w_if_win     = 1'b0;
      w_ahb_win    = 1'b0;
      w_cs         = 1'b0;
      w_we         = 1'b0;
      w_be         = 4'h0;
      w_addr       = '0;
      w_wdata      = '0;
      unique case (r_state)
         S_LOAD: begin
            if (!bus.load_active) w_state_nxt = S_RUN;
            w_starve_nxt = '0;
            w_cs    = bus.load_req;
            w_we    = bus.load_req;
            w_be    = 4'hF;
            w_addr  = bus.load_addr;
            w_wdata = bus.load_wdata;
         end
         S_RUN: begin
            if (bus.load_active) begin
               // reload blocks new grants this very cycle
               w_state_nxt  = S_LOAD;
               w_starve_nxt = '0;
            end else begin
               w_ahb_win = bus.ahb_req &&
                           (!bus.if_req || r_starve == LIMIT);
               w_if_win  = bus.if_req && !w_ahb_win;
               if (bus.ahb_req && !w_ahb_win)
                  w_starve_nxt = (r_starve == LIMIT) ? LIMIT
                                                     : r_starve + 3'd1;
               else
                  w_starve_nxt = '0;
               if (w_ahb_win) begin
                  w_cs      = 1'b1;
                  w_we      = bus.ahb_wr;
                  w_be      = bus.ahb_wr ? bus.ahb_be : 4'hF;
                  w_addr    = bus.ahb_addr;
                  w_wdata   = bus.ahb_wdata;
                  w_tag_nxt = bus.ahb_wr ? T_NONE : T_AHB;
               end else if (w_if_win) begin
                  w_cs      = 1'b1;
                  w_be      = 4'hF;
                  w_addr    = bus.if_addr;
                  w_tag_nxt = T_IF;
               end
            end
         end
         default: ;
      endcase
   end

   assign w_live = !rst;
   assign w_off  = w_addr - BASE;
   assign w_unused_off = ^{w_off[ADDR_WIDTH-1:WORD_AW+2], w_off[1:0]};

   assign bus.if_gnt     = w_live && w_if_win;
   assign bus.ahb_gnt    = w_live && w_ahb_win;
   assign bus.sram_cs    = w_live && w_cs;
   assign bus.sram_we    = w_live && w_we;
   assign bus.sram_be    = w_live ? w_be : 4'h0;
   assign bus.sram_addr  = (w_live && w_cs) ? w_off[WORD_AW+1:2] : '0;
   assign bus.sram_wdata = (w_live && w_cs) ? w_wdata : '0;

   assign bus.if_rvalid  = (r_tag == T_IF);
   assign bus.ahb_rvalid = (r_tag == T_AHB);
   assign bus.if_rdata   = w_live ? bus.sram_rdata : '0;
   assign bus.ahb_rdata  = w_live ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// Directed bench for itcm_port_arbiter with a behavioural single-port
// SRAM (1-cycle read latency, byte-enabled writes).
module tb_itcm_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   itcm_port_arbiter_if bus ();

   itcm_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:8191];
   logic [31:0] rd = 32'hDEADBEEF;

   always @(posedge clk) begin
      if (bus.sram_cs) begin
         if (bus.sram_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.sram_be[b])
                  mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
         end else begin
            rd <= mem[bus.sram_addr];
         end
      end
   end
   assign bus.sram_rdata = rd;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
      mem[13'h040] = 32'h12345678;
      mem[13'h041] = 32'h0BADF00D;
      mem[13'h080] = 32'hCAFEF00D;
      mem[13'h004] = 32'h11223344;

      rst = 1'b1;
      bus.load_active = 1'b1;
      bus.load_req    = 1'b0;
      bus.load_addr   = '0;
      bus.load_wdata  = '0;
      bus.if_req      = 1'b1;
      bus.if_addr     = 32'h100;
      bus.ahb_req     = 1'b0;
      bus.ahb_wr      = 1'b0;
      bus.ahb_addr    = '0;
      bus.ahb_be      = 4'h0;
      bus.ahb_wdata   = '0;

      #3;
      chk("rst_if_gnt", 32'(bus.if_gnt), 0);
      chk("rst_ahb_gnt", 32'(bus.ahb_gnt), 0);
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 0);
      chk("rst_ahb_rvalid", 32'(bus.ahb_rvalid), 0);
      chk("rst_cs", 32'(bus.sram_cs), 0);
      chk("rst_we", 32'(bus.sram_we), 0);
      chk("rst_be", 32'(bus.sram_be), 0);
      chk("rst_addr", 32'(bus.sram_addr), 0);
      chk("rst_wdata", bus.sram_wdata, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_ahb_rdata", bus.ahb_rdata, 0);

      cyc();
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.load_req   = 1'b1;
         bus.load_addr  = 32'(4 * i);
         bus.load_wdata = 32'hA0 + 32'(i);
         #2;
         chk("load_cs", 32'(bus.sram_cs), 1);
         chk("load_we", 32'(bus.sram_we), 1);
         chk("load_be", 32'(bus.sram_be), 32'hF);
         chk("load_addr", 32'(bus.sram_addr), 32'(i));
         chk("load_if_gnt", 32'(bus.if_gnt), 0);
         cyc();
      end

      bus.load_req    = 1'b0;
      bus.load_active = 1'b0;
      #2;
      chk("ldfall_if_gnt", 32'(bus.if_gnt), 0);
      chk("ldfall_cs", 32'(bus.sram_cs), 0);

      cyc();
      #2;
      chk("run_if_gnt", 32'(bus.if_gnt), 1);
      chk("run_addr", 32'(bus.sram_addr), 32'h40);
      chk("run_we", 32'(bus.sram_we), 0);
      cyc();
      bus.if_req = 1'b0;
      #2;
      chk("run_if_rvalid", 32'(bus.if_rvalid), 1);
      chk("run_if_rdata", bus.if_rdata, 32'h12345678);
      chk("run_if_gnt_idle", 32'(bus.if_gnt), 0);

      cyc();
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h104;
      bus.ahb_req  = 1'b1;
      bus.ahb_wr   = 1'b0;
      bus.ahb_addr = 32'h200;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("starve_ahb_gnt", 32'(bus.ahb_gnt), 0);
         chk("starve_if_gnt", 32'(bus.if_gnt), 1);
         cyc();
      end
      #2;
      chk("limit_ahb_gnt", 32'(bus.ahb_gnt), 1);
      chk("limit_if_gnt", 32'(bus.if_gnt), 0);
      chk("limit_addr", 32'(bus.sram_addr), 32'h80);
      cyc();
      bus.ahb_req = 1'b0;
      #2;
      chk("starve_ahb_rvalid", 32'(bus.ahb_rvalid), 1);
      chk("starve_ahb_rdata", bus.ahb_rdata, 32'hCAFEF00D);
      chk("starve_if_rvalid", 32'(bus.if_rvalid), 0);
      chk("resume_if_gnt", 32'(bus.if_gnt), 1);
      cyc();
      bus.if_req = 1'b0;
      #2;
      chk("resume_if_rvalid", 32'(bus.if_rvalid), 1);
      chk("resume_ahb_rvalid", 32'(bus.ahb_rvalid), 0);
      chk("resume_if_rdata", bus.if_rdata, 32'h0BADF00D);

      cyc();
      bus.ahb_req   = 1'b1;
      bus.ahb_wr    = 1'b1;
      bus.ahb_addr  = 32'h10;
      bus.ahb_be    = 4'b0011;
      bus.ahb_wdata = 32'hAABBCCDD;
      #2;
      chk("wr_ahb_gnt", 32'(bus.ahb_gnt), 1);
      chk("wr_we", 32'(bus.sram_we), 1);
      chk("wr_be", 32'(bus.sram_be), 32'h3);
      chk("wr_addr", 32'(bus.sram_addr), 32'h4);
      chk("wr_wdata", bus.sram_wdata, 32'hAABBCCDD);
      cyc();
      bus.ahb_req = 1'b0;
      bus.ahb_wr  = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      #2;
      chk("wr_no_rvalid", 32'(bus.ahb_rvalid), 0);
      chk("rbw_if_gnt", 32'(bus.if_gnt), 1);
      cyc();
      bus.if_req = 1'b0;
      #2;
      chk("rbw_if_rvalid", 32'(bus.if_rvalid), 1);
      chk("rbw_if_rdata", bus.if_rdata, 32'h1122CCDD);

      cyc();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h8;
      #2;
      chk("rl_if_gnt", 32'(bus.if_gnt), 1);
      cyc();
      bus.load_active = 1'b1;
      #2;
      chk("rl_if_rvalid", 32'(bus.if_rvalid), 1);
      chk("rl_if_rdata", bus.if_rdata, 32'hA2);
      chk("rl_if_gnt_blk", 32'(bus.if_gnt), 0);
      chk("rl_cs_blk", 32'(bus.sram_cs), 0);
      cyc();
      #2;
      chk("rl_if_gnt_ld", 32'(bus.if_gnt), 0);
      chk("rl_if_rvalid_ld", 32'(bus.if_rvalid), 0);
      chk("rl_cs_ld", 32'(bus.sram_cs), 0);

      cyc();
      bus.load_active = 1'b0;
      bus.if_req      = 1'b0;
      cyc();
      bus.ahb_req  = 1'b1;
      bus.ahb_wr   = 1'b0;
      bus.ahb_addr = 32'h200;
      #2;
      chk("ar_ahb_gnt", 32'(bus.ahb_gnt), 1);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_ahb_gnt_rst", 32'(bus.ahb_gnt), 0);
      chk("ar_cs_rst", 32'(bus.sram_cs), 0);
      cyc();
      bus.ahb_req = 1'b0;
      #1;
      chk("ar_ahb_rvalid", 32'(bus.ahb_rvalid), 0);
      chk("ar_if_rvalid", 32'(bus.if_rvalid), 0);
      chk("ar_cs", 32'(bus.sram_cs), 0);
      chk("ar_be", 32'(bus.sram_be), 0);
      chk("ar_ahb_rdata", bus.ahb_rdata, 0);
      cyc();
      rst = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      #2;
      chk("ar_ahb_rvalid_post", 32'(bus.ahb_rvalid), 0);
      chk("ar_if_gnt_sload", 32'(bus.if_gnt), 0);
      cyc();
      #2;
      chk("ar_if_gnt_run", 32'(bus.if_gnt), 1);
      cyc();
      bus.if_req = 1'b0;
      #2;
      chk("ar_if_rdata", bus.if_rdata, 32'h12345678);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
